// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bus bundle between the cache controllers, main memory and the port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 4
);
  localparam int BEAT_W = $clog2(BURST_LEN);

  // I side (read-only line fills)
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_rvalid;
  logic              i_done;

  // D side (line fill or writeback)
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_wready;
  logic [31:0]       d_rdata;
  logic              d_rvalid;
  logic              d_done;

  // burst position shared by both sides
  logic [BEAT_W-1:0] beat;

  // main memory port
  logic              m_re;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_data_in;
  logic [31:0]       m_data_out;
  logic              m_valid;

  // arbiter view
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_data_out, m_valid,
    output i_rdata, i_rvalid, i_done, d_wready, d_rdata, d_rvalid, d_done,
    output beat, m_re, m_we, m_addr, m_data_in
  );

  // requesters and memory view
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_data_out, m_valid,
    input  i_rdata, i_rvalid, i_done, d_wready, d_rdata, d_rvalid, d_done,
    input  beat, m_re, m_we, m_addr, m_data_in
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin burst sequencer sharing main memory between I and D cache controllers
module mem_port_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  mem_port_arbiter_if.slave  bus
);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN * 4 - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              take_i, take_d;

  // State register; last starts at D so the I side wins the first tie
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_I;
      we_q    <= 1'b0;
      last_q  <= OWN_D;
      addr_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
    end
  end

  // Grant in IDLE only, count beats in BUSY, one RELEASE cycle carries DONE
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    last_d  = last_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    take_i  = 1'b0;
    take_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        take_i = bus.i_req && (!bus.d_req || last_q == OWN_D);
        take_d = bus.d_req && (!bus.i_req || last_q == OWN_I);
        if (take_i) begin
          owner_d = OWN_I;
          we_d    = 1'b0;
          addr_d  = bus.i_addr & ~LINE_MASK;
          last_d  = OWN_I;
          beat_d  = '0;
          state_d = ST_BUSY;
        end else if (take_d) begin
          owner_d = OWN_D;
          we_d    = bus.d_we;
          addr_d  = bus.d_addr & ~LINE_MASK;
          last_d  = OWN_D;
          beat_d  = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.m_valid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  logic busy;
  logic rd_beat;

  assign busy    = (state_q == ST_BUSY);
  assign rd_beat = busy && !we_q && bus.m_valid;

  assign bus.m_re      = busy && !we_q;
  assign bus.m_we      = busy && we_q;
  assign bus.m_addr    = addr_q;
  assign bus.beat      = beat_q;
  assign bus.m_data_in = (busy && we_q) ? bus.d_wdata : '0;

  assign bus.i_rvalid = rd_beat && (owner_q == OWN_I);
  assign bus.i_rdata  = bus.i_rvalid ? bus.m_data_out : '0;
  assign bus.i_done   = (state_q == ST_RELEASE) && (owner_q == OWN_I);

  assign bus.d_rvalid = rd_beat && (owner_q == OWN_D);
  assign bus.d_rdata  = bus.d_rvalid ? bus.m_data_out : '0;
  assign bus.d_wready = busy && we_q && bus.m_valid;
  assign bus.d_done   = (state_q == ST_RELEASE) && (owner_q == OWN_D);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - cycle vector table plus arbitration sequences for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int BURST_LEN = 4;
  localparam int ADDR_W    = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) bus();
  mem_port_arbiter #(.BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic        m_re;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_din;
    logic [1:0]  beat;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_wready;
    logic        d_done;
  } outs_t;

  typedef struct {
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_valid;
    logic [31:0] m_dout;
    outs_t       exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];
  logic [31:0] grants[$];
  int gaps[$];
  logic prev_act;
  int low_run;

  function automatic outs_t mko(int re, int we, int addr, int din, int beat, int irv, int ird,
                                int idn, int drv, int drd, int dwr, int ddn);
    outs_t o;
    o.m_re = re[0]; o.m_we = we[0]; o.m_addr = addr; o.m_din = din; o.beat = beat[1:0];
    o.i_rvalid = irv[0]; o.i_rdata = ird; o.i_done = idn[0];
    o.d_rvalid = drv[0]; o.d_rdata = drd; o.d_wready = dwr[0]; o.d_done = ddn[0];
    return o;
  endfunction

  function automatic vec_t mkv(int rst, int ireq, int iaddr, int dreq, int dwe, int daddr,
                               int dwd, int mv, int md, outs_t e);
    vec_t v;
    v.rst_n = rst[0]; v.i_req = ireq[0]; v.i_addr = iaddr; v.d_req = dreq[0]; v.d_we = dwe[0];
    v.d_addr = daddr; v.d_wdata = dwd; v.m_valid = mv[0]; v.m_dout = md; v.exp = e;
    return v;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.m_re = bus.m_re; o.m_we = bus.m_we; o.m_addr = bus.m_addr; o.m_din = bus.m_data_in;
    o.beat = bus.beat; o.i_rvalid = bus.i_rvalid; o.i_rdata = bus.i_rdata; o.i_done = bus.i_done;
    o.d_rvalid = bus.d_rvalid; o.d_rdata = bus.d_rdata; o.d_wready = bus.d_wready;
    o.d_done = bus.d_done;
    return o;
  endfunction

  function automatic string fmt(outs_t o);
    return $sformatf("re=%b we=%b addr=%h din=%h beat=%0d irv=%b ird=%h idone=%b drv=%b drd=%h dwr=%b ddone=%b",
                     o.m_re, o.m_we, o.m_addr, o.m_din, o.beat, o.i_rvalid, o.i_rdata, o.i_done,
                     o.d_rvalid, o.d_rdata, o.d_wready, o.d_done);
  endfunction

  task automatic clear_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.m_valid = 1'b0; bus.m_data_out = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    grants.delete();
    gaps.delete();
    prev_act = 1'b0;
    low_run = 0;
  endtask

  // auto-responding memory: one beat per cycle while a burst is open
  task automatic step_auto();
    logic act;
    @(negedge clk);
    act = bus.m_re | bus.m_we;
    bus.m_valid = act;
    bus.m_data_out = 32'hC0 + 32'(bus.beat);
    if (act && !prev_act) begin
      grants.push_back(bus.m_addr);
      gaps.push_back(low_run);
      low_run = 0;
    end
    if (!act) low_run++;
    prev_act = act;
  endtask

  initial begin
    outs_t act;
    logic [31:0] exp_tie [4];

    // reset and I fill with a gap beat, I_REQ dropped mid-burst, spurious M_VALID in IDLE/RELEASE
    tbl.push_back(mkv(0,0,0,0,0,0,0,0,0,         mko(0,0,0,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(1,1,'h1234,0,0,0,0,1,'h77, mko(0,0,0,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(1,1,'h1234,0,0,0,0,0,0,    mko(1,0,'h1230,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(1,1,'h1234,0,0,0,0,1,'hA0, mko(1,0,'h1230,0,0,1,'hA0,0,0,0,0,0)));
    tbl.push_back(mkv(1,1,'h1234,0,0,0,0,1,'hA1, mko(1,0,'h1230,0,1,1,'hA1,0,0,0,0,0)));
    tbl.push_back(mkv(1,0,'h1234,0,0,0,0,0,0,    mko(1,0,'h1230,0,2,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(1,0,'h1234,0,0,0,0,1,'hA2, mko(1,0,'h1230,0,2,1,'hA2,0,0,0,0,0)));
    tbl.push_back(mkv(1,0,'h1234,0,0,0,0,1,'hA3, mko(1,0,'h1230,0,3,1,'hA3,0,0,0,0,0)));
    tbl.push_back(mkv(1,0,'h1234,0,0,0,0,1,'h55, mko(0,0,'h1230,0,0,0,0,1,0,0,0,0)));
    tbl.push_back(mkv(1,0,'h1234,0,0,0,0,1,'h66, mko(0,0,'h1230,0,0,0,0,0,0,0,0,0)));
    // D writeback, D_ADDR/D_WE changes mid-burst ignored
    tbl.push_back(mkv(1,0,0,1,1,'h2008,'hD0,0,0,   mko(0,0,'h1230,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(1,0,0,1,1,'h2008,'hD0,0,0,   mko(0,1,'h2000,'hD0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(1,0,0,1,1,'h2008,'hD0,1,0,   mko(0,1,'h2000,'hD0,0,0,0,0,0,0,1,0)));
    tbl.push_back(mkv(1,0,0,1,0,'h9000,'hD1,1,0,   mko(0,1,'h2000,'hD1,1,0,0,0,0,0,1,0)));
    tbl.push_back(mkv(1,0,0,1,0,'h9000,'hD2,1,'h99,mko(0,1,'h2000,'hD2,2,0,0,0,0,0,1,0)));
    tbl.push_back(mkv(1,0,0,1,1,'h2008,'hD3,1,0,   mko(0,1,'h2000,'hD3,3,0,0,0,0,0,1,0)));
    tbl.push_back(mkv(1,0,0,0,0,0,'hEE,0,0,        mko(0,0,'h2000,0,0,0,0,0,0,0,0,1)));
    tbl.push_back(mkv(1,0,0,0,0,0,0,0,0,           mko(0,0,'h2000,0,0,0,0,0,0,0,0,0)));
    // D fill routed to D side only
    tbl.push_back(mkv(1,0,0,1,0,'h303C,0,0,0,      mko(0,0,'h2000,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(1,0,0,1,0,'h303C,0,1,'hB0,   mko(1,0,'h3030,0,0,0,0,0,1,'hB0,0,0)));
    tbl.push_back(mkv(1,0,0,1,0,'h303C,0,1,'hB1,   mko(1,0,'h3030,0,1,0,0,0,1,'hB1,0,0)));
    tbl.push_back(mkv(1,0,0,1,0,'h303C,0,1,'hB2,   mko(1,0,'h3030,0,2,0,0,0,1,'hB2,0,0)));
    tbl.push_back(mkv(1,0,0,1,0,'h303C,0,1,'hB3,   mko(1,0,'h3030,0,3,0,0,0,1,'hB3,0,0)));
    tbl.push_back(mkv(1,0,0,0,0,0,0,0,0,           mko(0,0,'h3030,0,0,0,0,0,0,0,0,1)));
    // reset after beat 1 of an I fill, then a fresh grant from beat 0
    tbl.push_back(mkv(1,1,'h4444,0,0,0,0,0,0,      mko(0,0,'h3030,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(1,1,'h4444,0,0,0,0,1,'hC0,   mko(1,0,'h4440,0,0,1,'hC0,0,0,0,0,0)));
    tbl.push_back(mkv(1,1,'h4444,0,0,0,0,1,'hC1,   mko(1,0,'h4440,0,1,1,'hC1,0,0,0,0,0)));
    tbl.push_back(mkv(0,1,'h4444,0,0,0,0,0,0,      mko(1,0,'h4440,0,2,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(1,1,'h5678,0,0,0,0,1,'hC3,   mko(0,0,0,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(1,1,'h5678,0,0,0,0,1,'hE0,   mko(1,0,'h5670,0,0,1,'hE0,0,0,0,0,0)));

    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      rst_n = tbl[k].rst_n;
      bus.i_req = tbl[k].i_req; bus.i_addr = tbl[k].i_addr;
      bus.d_req = tbl[k].d_req; bus.d_we = tbl[k].d_we;
      bus.d_addr = tbl[k].d_addr; bus.d_wdata = tbl[k].d_wdata;
      bus.m_valid = tbl[k].m_valid; bus.m_data_out = tbl[k].m_dout;
      #1;
      act = sample();
      total++;
      if (act !== tbl[k].exp) begin
        bad++;
        $display("FAIL vec%0d got {%s} want {%s}", k, fmt(act), fmt(tbl[k].exp));
      end
    end

    // simultaneous requests: I first, then strict alternation
    exp_tie = '{32'h100, 32'h200, 32'h100, 32'h200};
    do_reset();
    rst_n = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h104;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20C;
    for (int c = 0; c < 80 && grants.size() < 4; c++) step_auto();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= grants.size()) begin
        bad++;
        $display("FAIL tie_grant%0d got none within budget want %h", k, exp_tie[k]);
      end else if (grants[k] !== exp_tie[k]) begin
        bad++;
        $display("FAIL tie_grant%0d got %h want %h", k, grants[k], exp_tie[k]);
      end
    end

    // D alone held: back-to-back bursts, memory idle in RELEASE and IDLE between them
    do_reset();
    rst_n = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h60C; bus.d_wdata = 32'h11;
    for (int c = 0; c < 80 && grants.size() < 4; c++) step_auto();
    for (int k = 1; k < 4; k++) begin
      total++;
      if (k >= grants.size()) begin
        bad++;
        $display("FAIL d_burst%0d got none within budget want addr 600", k);
      end else if (grants[k] !== 32'h600 || gaps[k] != 2) begin
        bad++;
        $display("FAIL d_burst%0d got addr=%h gap=%0d want addr=600 gap=2", k, grants[k], gaps[k]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
